// File: rtl/regfile_streamer.sv
// Reader-side sequencer: sweeps a contiguous regfile address range through one read port
// and emits each word on a valid/ready stream, flagging the final word with out_last.
module regfile_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [CNT_WIDTH-1:0]  CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_rf_read_addr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  w_last_word;
  logic                  w_xfer;

  assign w_last_word = (r_remaining == CntOne);
  assign w_xfer      = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rf_read_addr <= '0;
      r_remaining    <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      // A transfer coinciding with abort has already completed at the sink.
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_rf_read_addr <= base_addr;
              r_remaining    <= count;
              r_state        <= FETCH;
            end else begin
              r_state <= FIN;
            end
          end
        end
        FETCH: begin
          r_out_data  <= rf_read_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_last_word;
          r_state     <= OUT;
        end
        OUT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_last_word) begin
              r_state <= FIN;
            end else begin
              r_remaining    <= r_remaining - CntOne;
              r_rf_read_addr <= r_rf_read_addr + AddrOne;
              r_state        <= FETCH;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rf_read_addr = r_rf_read_addr;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == FIN);

endmodule

// File: tb/tb_regfile_streamer.sv
// Directed bench for regfile_streamer: a behavioural regfile answers the read port and
// each step compares the stream against hand-derived words and timing.
module tb_regfile_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  count = '0;
  logic        abort = 1'b0;
  logic [4:0]  rf_read_addr;
  logic [15:0] rf_read_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_read_data = mem[rf_read_addr];

  regfile_streamer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(5),
    .CNT_WIDTH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .count        (count),
    .abort        (abort),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full dump with `stalls` ready-low cycles per word; optional start pulse mid-dump.
  task automatic dump(input logic [4:0] base, input logic [5:0] cnt, input int stalls,
                      input bit poke);
    logic [4:0]  a;
    logic [15:0] w;
    a = base;
    out_ready = (stalls == 0);
    start = 1'b1; base_addr = base; count = cnt;
    tick();
    start = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_valid", out_valid, 0);
    chk("acc_addr", rf_read_addr, base);
    tick();
    for (int k = 0; k < int'(cnt); k++) begin
      w = mem[a];
      chk("word_valid", out_valid, 1);
      chk("word_data", out_data, w);
      chk("word_last", out_last, (k == int'(cnt) - 1));
      for (int s = 0; s < stalls; s++) begin
        out_ready = 1'b0;
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, w);
        chk("stall_last", out_last, (k == int'(cnt) - 1));
      end
      out_ready = 1'b1;
      if (poke && k == 2) begin
        start = 1'b1; base_addr = 5'd20; count = 6'd3;
      end
      tick();
      start = 1'b0;
      if (stalls != 0) out_ready = 1'b0;
      if (k == int'(cnt) - 1) begin
        chk("fin_done", done, 1);
        chk("fin_valid", out_valid, 0);
        chk("fin_busy", busy, 1);
      end else begin
        chk("fetch_valid", out_valid, 0);
        chk("fetch_done", done, 0);
        tick();
      end
      a = a + 5'd1;
    end
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);

    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", rf_read_addr, 0);
    rst = 1'b0;
    tick();

    // Full-depth dump, then address wrap.
    dump(5'd0, 6'd32, 0, 1'b0);
    dump(5'd30, 6'd4, 0, 1'b0);
    // Backpressure: ready low two cycles per word.
    dump(5'd5, 6'd3, 2, 1'b0);

    // Zero-count start: no stream, one-cycle busy with done.
    out_ready = 1'b1;
    start = 1'b1; base_addr = 5'd9; count = 6'd0;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_done", done, 1);
    chk("zero_valid", out_valid, 0);
    tick();
    chk("zero_busy_end", busy, 0);
    chk("zero_done_end", done, 0);
    chk("zero_valid_end", out_valid, 0);

    // Start while busy is ignored: still exactly 8 words.
    dump(5'd10, 6'd8, 0, 1'b1);

    // Abort while the third word is waiting.
    out_ready = 1'b1;
    start = 1'b1; base_addr = 5'd0; count = 6'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("ab_word1", out_data, 16'd1);
    tick();
    tick();
    chk("ab_word2_valid", out_valid, 1);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_last", out_last, 0);
    tick();
    chk("ab_done_later", done, 0);
    mem[0] = 16'h5A5A;
    dump(5'd0, 6'd1, 0, 1'b0);

    // Asynchronous reset mid-OUT, between clock edges.
    out_ready = 1'b0;
    start = 1'b1; base_addr = 5'd3; count = 6'd4;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    chk("arst_addr", rf_read_addr, 0);
    chk("arst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    dump(5'd0, 6'd2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
